// File: rtl/game_pkg.sv
// Shared encodings for the match controller: FSM states, round-result
// codes reported by the game datapath, and the match_winner encoding.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_LOAD,
    ST_PLAY,
    ST_SCORE,
    ST_DONE
  } state_t;

  // game_who, relative to the player who owns the round
  localparam logic [1:0] WHO_NONE  = 2'b00;
  localparam logic [1:0] WHO_OWNER = 2'b01;
  localparam logic [1:0] WHO_OTHER = 2'b10;

  // match_winner
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P0   = 2'b01;
  localparam logic [1:0] WIN_P1   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

endpackage

// File: rtl/round_timer.sv
// Per-round PLAY cycle counter; expired marks the TIMEOUT-th enabled cycle.
module round_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  // Flag the cycle whose increment brings the count to TIMEOUT.
  assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/game_match_ctrl.sv
// Best-of-ROUNDS match controller sequencing reset/load/play/score of a game
// datapath, tracking per-player scores and the match winner.
module game_match_ctrl
  import game_pkg::*;
#(
  parameter int unsigned mmcINPUT = 4,
  parameter int unsigned ROUNDS   = 3,
  parameter int unsigned TIMEOUT  = 255,
  localparam int unsigned SW      = $clog2(ROUNDS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                p0_req,
  input  logic                p1_req,
  input  logic [1:0]          p0_mode,
  input  logic [1:0]          p1_mode,
  input  logic [mmcINPUT-1:0] seed,
  input  logic                game_over,
  input  logic [1:0]          game_who,
  output logic                game_rst,
  output logic                game_init,
  output logic [1:0]          game_ctrl,
  output logic [mmcINPUT-1:0] game_value,
  output logic                owner,
  output logic [SW-1:0]       score0,
  output logic [SW-1:0]       score1,
  output logic                busy,
  output logic                match_done,
  output logic [1:0]          match_winner
);

  localparam int unsigned WIN_SCORE = ROUNDS / 2 + 1;
  localparam int unsigned SMAX      = (1 << SW) - 1;

  state_t              state, nxt_state;
  logic [SW-1:0]       round, nxt_round;
  logic [1:0]          result, nxt_result;
  logic [SW-1:0]       nxt_score0, nxt_score1;
  logic                nxt_owner;
  logic [1:0]          nxt_ctrl;
  logic [mmcINPUT-1:0] nxt_value;
  logic [1:0]          nxt_winner;
  logic                credit0, credit1;
  logic                expired;

  round_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_round_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state != ST_PLAY),
    .enable  (state == ST_PLAY),
    .expired (expired)
  );

  always_comb begin
    nxt_state  = state;
    nxt_round  = round;
    nxt_result = result;
    nxt_score0 = score0;
    nxt_score1 = score1;
    nxt_owner  = owner;
    nxt_ctrl   = game_ctrl;
    nxt_value  = game_value;
    nxt_winner = WIN_NONE;
    credit0    = 1'b0;
    credit1    = 1'b0;

    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          nxt_score0 = '0;
          nxt_score1 = '0;
          nxt_round  = '0;
          nxt_owner  = 1'b0;
          nxt_state  = ST_CLR;
        end
      end
      ST_CLR: begin
        nxt_value = mmcINPUT'(seed + mmcINPUT'(round));
        nxt_ctrl  = 2'b00;
        nxt_state = ST_LOAD;
      end
      ST_LOAD: nxt_state = ST_PLAY;
      ST_PLAY: begin
        if (owner ? p1_req : p0_req) begin
          nxt_ctrl = owner ? p1_mode : p0_mode;
        end
        // game_over wins over a simultaneous expiry; a timeout scores nothing.
        if (game_over || expired) begin
          nxt_result = game_over ? game_who : WHO_NONE;
          nxt_state  = ST_SCORE;
        end
      end
      ST_SCORE: begin
        if (result == WHO_OWNER) begin
          credit0 = !owner;
          credit1 = owner;
        end else if (result == WHO_OTHER) begin
          credit0 = owner;
          credit1 = !owner;
        end
        if (credit0 && score0 != SW'(SMAX)) nxt_score0 = score0 + SW'(1);
        if (credit1 && score1 != SW'(SMAX)) nxt_score1 = score1 + SW'(1);
        nxt_round = round + SW'(1);
        nxt_owner = !owner;
        if (nxt_score0 >= SW'(WIN_SCORE) || nxt_score1 >= SW'(WIN_SCORE) ||
            nxt_round == SW'(ROUNDS)) begin
          nxt_state = ST_DONE;
        end else begin
          nxt_state = ST_CLR;
        end
      end
      default: nxt_state = ST_IDLE;
    endcase

    if (nxt_state == ST_DONE) begin
      if (nxt_score0 > nxt_score1)      nxt_winner = WIN_P0;
      else if (nxt_score1 > nxt_score0) nxt_winner = WIN_P1;
      else                              nxt_winner = WIN_TIE;
    end
  end

  // Outputs are decoded from the next state so they line up with the state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      round        <= '0;
      result       <= WHO_NONE;
      score0       <= '0;
      score1       <= '0;
      owner        <= 1'b0;
      game_ctrl    <= 2'b00;
      game_value   <= '0;
      game_rst     <= 1'b0;
      game_init    <= 1'b0;
      busy         <= 1'b0;
      match_done   <= 1'b0;
      match_winner <= WIN_NONE;
    end else begin
      state        <= nxt_state;
      round        <= nxt_round;
      result       <= nxt_result;
      score0       <= nxt_score0;
      score1       <= nxt_score1;
      owner        <= nxt_owner;
      game_ctrl    <= nxt_ctrl;
      game_value   <= nxt_value;
      game_rst     <= !(nxt_state == ST_IDLE || nxt_state == ST_CLR);
      game_init    <= (nxt_state == ST_LOAD);
      busy         <= !(nxt_state == ST_IDLE || nxt_state == ST_DONE);
      match_done   <= (nxt_state == ST_DONE);
      match_winner <= nxt_winner;
    end
  end

endmodule

// File: tb/tb_game_match_ctrl.sv
// Randomized self-checking bench for game_match_ctrl against a round-level
// model of match scoring, owner alternation and round timing.
module tb_game_match_ctrl;

  localparam int unsigned W       = 4;
  localparam int unsigned ROUNDS  = 3;
  localparam int unsigned TIMEOUT = 255;
  localparam int          SMAX    = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         p0_req = 1'b0, p1_req = 1'b0;
  logic [1:0]   p0_mode = 2'b00, p1_mode = 2'b00;
  logic [W-1:0] seed = '0;
  logic         game_over = 1'b0;
  logic [1:0]   game_who = 2'b00;
  logic         game_rst, game_init, owner, busy, match_done;
  logic [1:0]   game_ctrl, match_winner;
  logic [W-1:0] game_value;
  logic [1:0]   score0, score1;

  int errors = 0;
  int checks = 0;

  // round-level reference state
  int           m_s0, m_s1, m_r;
  logic         m_owner;
  logic [1:0]   m_ctrl;
  bit           m_done;
  logic [W-1:0] seed_v;

  game_match_ctrl #(
    .mmcINPUT (W),
    .ROUNDS   (ROUNDS),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .p0_req       (p0_req),
    .p1_req       (p1_req),
    .p0_mode      (p0_mode),
    .p1_mode      (p1_mode),
    .seed         (seed),
    .game_over    (game_over),
    .game_who     (game_who),
    .game_rst     (game_rst),
    .game_init    (game_init),
    .game_ctrl    (game_ctrl),
    .game_value   (game_value),
    .owner        (owner),
    .score0       (score0),
    .score1       (score1),
    .busy         (busy),
    .match_done   (match_done),
    .match_winner (match_winner)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  task automatic test_reset(input int n);
    rst = 1'b0; start = 1'b0; game_over = 1'b0; game_who = 2'b00;
    p0_req = 1'b0; p1_req = 1'b0;
    repeat (n) @(negedge clk);
    checks++;
    if ({game_rst, game_init, game_ctrl, game_value, owner, score0, score1,
         busy, match_done, match_winner} !== '0) begin
      errors++;
      $display("FAIL reset: rst=%b init=%b ctrl=%b value=%h owner=%b s0=%0d s1=%0d busy=%b done=%b win=%b required all zero",
               game_rst, game_init, game_ctrl, game_value, owner, score0, score1, busy, match_done, match_winner);
    end
    rst = 1'b1;
    m_s0 = 0; m_s1 = 0; m_r = 0; m_owner = 1'b0; m_ctrl = 2'b00; m_done = 1'b0;
  endtask

  // Called at a negedge in IDLE or DONE; returns at the negedge in CLR.
  task automatic start_match(input logic [W-1:0] s);
    seed_v = s;
    seed   = s;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_s0 = 0; m_s1 = 0; m_r = 0; m_owner = 1'b0; m_done = 1'b0;
    checks++;
    if ({game_rst, game_init, busy, match_done, owner, score0, score1} !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0}) begin
      errors++;
      $display("FAIL clear: rst=%b init=%b busy=%b done=%b owner=%b s0=%0d s1=%0d required rst=0 init=0 busy=1 done=0 owner=0 s0=0 s1=0",
               game_rst, game_init, busy, match_done, owner, score0, score1);
    end
  endtask

  // Runs one round from the CLR negedge. game_over is raised in PLAY cycle d
  // (d > TIMEOUT means never). mode: 0 quiet, 1 random requests/start,
  // 2 scripted non-owner then owner request. abort>0 resets in that PLAY cycle.
  task automatic run_round(input int d, input logic [1:0] who, input int mode, input int abort);
    int           plays;
    int           res;
    logic         wp;
    logic [1:0]   ew;
    logic [W-1:0] ev;
    ev = W'(seed_v + m_r);
    @(negedge clk);
    checks++;
    if ({game_init, game_rst, busy, game_value, owner, game_ctrl, score0, score1} !==
        {1'b1, 1'b1, 1'b1, ev, m_owner, 2'b00, 2'(m_s0), 2'(m_s1)}) begin
      errors++;
      $display("FAIL load r%0d: init=%b rst=%b busy=%b value=%0d owner=%b ctrl=%b s0=%0d s1=%0d required init=1 rst=1 busy=1 value=%0d owner=%b ctrl=00 s0=%0d s1=%0d",
               m_r, game_init, game_rst, busy, game_value, owner, game_ctrl, score0, score1, ev, m_owner, m_s0, m_s1);
    end
    m_ctrl = 2'b00;
    if (mode == 1) begin
      p0_req = 1'($urandom_range(0, 1)); p0_mode = 2'($urandom);
      p1_req = 1'($urandom_range(0, 1)); p1_mode = 2'($urandom);
    end
    plays = (d <= int'(TIMEOUT)) ? d : int'(TIMEOUT);
    for (int c = 1; c <= plays; c++) begin
      @(negedge clk);
      checks++;
      if ({game_init, game_rst, busy, match_done, game_ctrl} !== {1'b0, 1'b1, 1'b1, 1'b0, m_ctrl}) begin
        errors++;
        $display("FAIL play r%0d c%0d: init=%b rst=%b busy=%b done=%b ctrl=%b required init=0 rst=1 busy=1 done=0 ctrl=%b",
                 m_r, c, game_init, game_rst, busy, match_done, game_ctrl, m_ctrl);
      end
      if (c == abort) begin
        test_reset(1);
        return;
      end
      p0_req = 1'b0; p1_req = 1'b0; start = 1'b0;
      if (mode == 1) begin
        p0_req = 1'($urandom_range(0, 1)); p0_mode = 2'($urandom);
        p1_req = 1'($urandom_range(0, 1)); p1_mode = 2'($urandom);
        start  = ($urandom_range(0, 7) == 0);
      end else if (mode == 2 && c == 1) begin
        p1_req = 1'b1; p1_mode = 2'b11;
      end else if (mode == 2 && c == 2) begin
        p0_req = 1'b1; p0_mode = 2'b10;
      end
      if (m_owner ? p1_req : p0_req) m_ctrl = m_owner ? p1_mode : p0_mode;
      if (c == d) begin
        game_over = 1'b1;
        game_who  = who;
      end
    end
    @(negedge clk);
    game_over = 1'b0; game_who = 2'b00; p0_req = 1'b0; p1_req = 1'b0; start = 1'b0;
    checks++;
    if ({game_init, game_rst, busy, match_done, game_ctrl} !== {1'b0, 1'b1, 1'b1, 1'b0, m_ctrl}) begin
      errors++;
      $display("FAIL score r%0d: init=%b rst=%b busy=%b done=%b ctrl=%b required init=0 rst=1 busy=1 done=0 ctrl=%b",
               m_r, game_init, game_rst, busy, match_done, game_ctrl, m_ctrl);
    end
    res = (d <= int'(TIMEOUT)) ? int'(who) : 0;
    if (res == 1 || res == 2) begin
      wp = (res == 1) ? m_owner : !m_owner;
      if (wp == 1'b0) m_s0 = (m_s0 < SMAX) ? m_s0 + 1 : SMAX;
      else            m_s1 = (m_s1 < SMAX) ? m_s1 + 1 : SMAX;
    end
    m_r++;
    m_owner = !m_owner;
    m_done  = (m_s0 >= int'(ROUNDS / 2 + 1)) || (m_s1 >= int'(ROUNDS / 2 + 1)) || (m_r >= int'(ROUNDS));
    @(negedge clk);
    checks++;
    if (m_done) begin
      ew = (m_s0 > m_s1) ? 2'b01 : (m_s1 > m_s0) ? 2'b10 : 2'b11;
      if ({game_rst, game_init, busy, match_done, match_winner, score0, score1} !==
          {1'b1, 1'b0, 1'b0, 1'b1, ew, 2'(m_s0), 2'(m_s1)}) begin
        errors++;
        $display("FAIL done r%0d: rst=%b init=%b busy=%b done=%b win=%b s0=%0d s1=%0d required rst=1 init=0 busy=0 done=1 win=%b s0=%0d s1=%0d",
                 m_r, game_rst, game_init, busy, match_done, match_winner, score0, score1, ew, m_s0, m_s1);
      end
    end else begin
      if ({game_rst, game_init, busy, match_done, match_winner, score0, score1, owner} !==
          {1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'(m_s0), 2'(m_s1), m_owner}) begin
        errors++;
        $display("FAIL next r%0d: rst=%b init=%b busy=%b done=%b win=%b s0=%0d s1=%0d owner=%b required rst=0 init=0 busy=1 done=0 win=00 s0=%0d s1=%0d owner=%b",
                 m_r, game_rst, game_init, busy, match_done, match_winner, score0, score1, owner, m_s0, m_s1, m_owner);
      end
    end
  endtask

  task automatic finish_match();
    while (!m_done) run_round(int'($urandom_range(1, 10)), 2'($urandom), 1, 0);
  endtask

  task automatic test_load_and_modes();
    start_match(4'd4);
    run_round(5, 2'b01, 2, 0);
  endtask

  task automatic test_alternating_owner();
    run_round(4, 2'b01, 0, 0);
    run_round(6, 2'b00, 1, 0);
  endtask

  task automatic test_timeout();
    start_match(4'd9);
    run_round(TIMEOUT + 1, 2'b01, 0, 0);
    run_round(TIMEOUT, 2'b01, 0, 0);
    run_round(TIMEOUT + 1, 2'b10, 1, 0);
  endtask

  task automatic test_score_win();
    start_match(4'd15);
    run_round(2, 2'b01, 0, 0);
    run_round(1, 2'b10, 0, 0);
    repeat (3) @(negedge clk);
    checks++;
    if ({match_done, busy, match_winner, score0, score1} !== {1'b1, 1'b0, 2'b01, 2'd2, 2'd0}) begin
      errors++;
      $display("FAIL done_hold: done=%b busy=%b win=%b s0=%0d s1=%0d required done=1 busy=0 win=01 s0=2 s1=0",
               match_done, busy, match_winner, score0, score1);
    end
  endtask

  task automatic test_reset_mid_play();
    start_match(4'd7);
    @(negedge clk);
    checks++;
    if (game_init !== 1'b1) begin
      errors++;
      $display("FAIL load_before_reset: init=%b required 1", game_init);
    end
    test_reset(1);
    start_match(4'd7);
    run_round(10, 2'b01, 1, 4);
    start_match(4'd3);
    run_round(2, 2'b10, 0, 0);
    finish_match();
  endtask

  task automatic test_back_to_back();
    for (int m = 0; m < 8; m++) begin
      start_match(W'($urandom));
      while (!m_done) begin
        if ($urandom_range(0, 9) == 0)
          run_round(int'(TIMEOUT) + 1, 2'($urandom), 1, 0);
        else
          run_round(int'($urandom_range(1, 12)), 2'($urandom), 1, 0);
      end
    end
  endtask

  initial begin
    test_reset(2);
    test_load_and_modes();
    test_alternating_owner();
    test_timeout();
    test_score_win();
    test_reset_mid_play();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_match_ctrl.md
GAME_MATCH_CTRL -- requirements
Module: game_match_ctrl

Interface
REQ-001 SHALL have parameter mmcINPUT, default 4, width of the seed and game_value buses.
REQ-002 SHALL have parameter ROUNDS, default 3, odd number of rounds in a best-of match.
REQ-003 SHALL have parameter TIMEOUT, default 255, the maximum number of PLAY cycles per round.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, with all state updating on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: match start request.
REQ-007 SHALL have ports p0_req and p1_req, input, 1 bit each: player mode-change request.
REQ-008 SHALL have ports p0_mode and p1_mode, input, 2 bits each: the mode requested by each player.
REQ-009 SHALL have port seed, input, mmcINPUT bits: base initial value.
REQ-010 SHALL have ports game_over, input, 1 bit, and game_who, input, 2 bits: status from the game datapath.
REQ-011 SHALL have port game_rst, output, 1 bit: active-low reset to the game datapath.
REQ-012 SHALL have port game_init, output, 1 bit: load strobe to the game datapath.
REQ-013 SHALL have port game_ctrl, output, 2 bits: controlValue to the game datapath.
REQ-014 SHALL have port game_value, output, mmcINPUT bits: initialValue to the game datapath.
REQ-015 SHALL have port owner, output, 1 bit: the player who owns the current round.
REQ-016 SHALL have ports score0 and score1, output, SW = $clog2(ROUNDS+1) bits each: rounds won by each player.
REQ-017 SHALL have ports busy and match_done, output, 1 bit each.
REQ-018 SHALL have port match_winner, output, 2 bits: 01 = player 0, 10 = player 1, 11 = tie.

Function
REQ-019 SHALL implement the FSM states IDLE, CLR, LOAD, PLAY, SCORE and DONE, with all outputs registered.
REQ-020 SHALL, in IDLE with start=1, clear score0, score1, the round count and owner, then go to CLR on the next edge; start while busy SHALL be ignored.
REQ-021 SHALL hold game_rst=0 for exactly one cycle in CLR, then go to LOAD; game_rst SHALL be 0 in IDLE and 1 in every other state.
REQ-022 SHALL hold game_init=1 for exactly one cycle in LOAD, with game_value = seed + round (truncated modulo 2^mmcINPUT), then go to PLAY.
REQ-023 SHALL, in PLAY, update game_ctrl to p<owner>_mode on any cycle where p<owner>_req=1; otherwise game_ctrl SHALL hold; requests from the non-owner SHALL be ignored.
REQ-024 SHALL reset game_ctrl to 00 at each LOAD.
REQ-025 SHALL, in PLAY, increment the timeout counter every cycle and go to SCORE when game_over=1 or the counter reaches TIMEOUT.
REQ-026 SHALL give game_over priority when game_over and timeout occur in the same cycle.
REQ-027 SHALL, in SCORE on a game_over exit, credit the owner when game_who=01 and the non-owner when game_who=10.
REQ-028 SHALL, in SCORE on a game_over exit with game_who=00 or 11, credit no player (draw).
REQ-029 SHALL credit no player in SCORE on a timeout exit.
REQ-030 SHALL, in SCORE, increment the round count and toggle owner.
REQ-031 SHALL go from SCORE to DONE when either score reaches ROUNDS/2+1 or the round count reaches ROUNDS; otherwise it SHALL go to CLR.
REQ-032 SHALL, in DONE, hold match_done=1 and set match_winner from the higher score (11 if equal).
REQ-033 SHALL hold scores in DONE until start=1, which returns to CLR with scores cleared, as in IDLE.
REQ-034 SHALL hold busy=1 in all states except IDLE and DONE.
REQ-035 SHALL saturate score counters and never wrap them.

Reset
REQ-036 SHALL, while rst=0 at a clock edge, set state=IDLE; game_rst=0; game_init=0; game_ctrl=00; game_value=0; owner=0; scores=0; busy=0; match_done=0; match_winner=00; timeout counter and round count=0.
REQ-037 SHALL let reset asserted in any state, including mid-PLAY, override all transitions, discard the round and drop game_init immediately.

Structure
REQ-038 SHALL place the FSM state enum and the match_winner/game_who encodings in a shared package, game_pkg.
REQ-039 SHALL implement the timeout counter as one sub-module, round_timer, with inputs clear and enable and output expired.
REQ-040 SHALL implement the rest of the block, the FSM and the score/round logic, in game_match_ctrl.

Verification
REQ-041 SHALL cover this scenario: seed=4, start pulse -> game_rst low for 1 cycle, then game_init=1 with game_value=4, owner=0.
REQ-042 SHALL cover this scenario: PLAY with owner=0, p1_req=1 and p1_mode=11, then p0_req=1 and p0_mode=10 -> game_ctrl stays 00, then becomes 10.
REQ-043 SHALL cover this scenario: game_over=1 with game_who=01 in rounds 1 and 2 -> score0=1 and score1=1 (owners alternate), round 3 LOAD has game_value=seed+2.
REQ-044 SHALL cover this scenario: no game_over for 255 PLAY cycles -> SCORE with no credit; game_over and expiry in the same cycle -> game_over credited.
REQ-045 SHALL cover this scenario: score0 reaches 2 with ROUNDS=3 -> DONE after round 2, match_done=1, match_winner=01, busy=0.
REQ-046 SHALL cover this scenario: rst=0 mid-PLAY -> next cycle all outputs at reset values; a following start begins round 0.
